// File: rtl/ball_pkg.sv
// Shared constants and types for the ball launcher.
// Positions are kept in quarter-pixel fixed point inside the launcher;
// the *_Q constants below are the same quantities already scaled by 4.
// Optional feature macro used by ball_launcher: BALL_TRAIL_EN.
package ball_pkg;

    localparam int START_X   = 42;
    localparam int START_Y   = 425;
    localparam int GROUND_Y  = 425;
    localparam int X_MAX     = 639;
    localparam int GRAVITY   = 1;
    localparam int HOLD      = 32;
    localparam int SCREEN_W  = 640;
    localparam int BALL_SIZE = 4;
    localparam int TRAIL_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        FLIGHT,
        LANDED
    } state_t;

    localparam logic [11:0]        X_START_Q = 12'(4 * START_X);
    localparam logic [10:0]        Y_START_Q = 11'(4 * START_Y);
    localparam logic signed [12:0] GROUND_Q  = 13'(4 * GROUND_Y);
    localparam logic signed [12:0] X_EDGE_Q  = 13'(4 * SCREEN_W);
    localparam logic [11:0]        X_MAX_Q   = 12'(4 * X_MAX);
    localparam logic [4:0]         HOLD_LAST = 5'(HOLD - 1);

    // Launch speed component: (power + 1) * angle steps, in quarter-pixels per tick.
    function automatic logic [6:0] scale_speed(input logic [2:0] vel, input logic [4:0] steps);
        return 7'((8'(vel) + 8'd1) * 8'(steps));
    endfunction

endpackage

// File: rtl/ball_pixel.sv
// Registered 4x4 sprite hit test against the current VGA pixel coordinate.
// The hit output lags the pixel coordinate by one clock.
module ball_pixel
    import ball_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    output logic       hit
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_x;
    logic        in_y;

    // Widened end coordinates so objects near the 10-bit limit do not wrap.
    assign x_end = {1'b0, obj_x} + 11'(BALL_SIZE);
    assign y_end = {1'b0, obj_y} + 11'(BALL_SIZE);
    assign in_x  = (px >= obj_x) && ({1'b0, px} < x_end);
    assign in_y  = (py >= obj_y) && ({1'b0, py} < y_end);

    // Register the hit so the pixel output is glitch-free and one clock behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit <= 1'b0;
        end else begin
            hit <= in_x && in_y;
        end
    end

endmodule

// File: rtl/ball_launcher.sv
// Projectile launcher: a ball fired from the start point with a chosen power
// and angle, stepped once per frame tick under constant gravity until it hits
// the ground or the right screen edge, held there, then returned to start.
// Optional feature macro: BALL_TRAIL_EN (4-entry motion trail display).
module ball_launcher
    import ball_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic       fire,
    input  logic [2:0] Vel,
    input  logic [4:0] Ang,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    output logic       ball,
    output logic       trail,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       busy,
    output logic       landed
);

    state_t             state_q, state_d;
    logic [11:0]        x_q, x_d;
    logic [10:0]        y_q, y_d;
    logic [6:0]         vx_q, vx_d;
    logic signed [7:0]  vy_q, vy_d;
    logic               armed_q, armed_d;
    logic [4:0]         hold_q, hold_d;
    logic               landed_d;

    logic [6:0]         vx_launch;
    logic [6:0]         vy_launch;
    logic signed [12:0] nx;
    logic signed [12:0] ny;
    logic               hit_ground;
    logic               hit_edge;

    // Launch velocity split: horizontal share shrinks as the angle step rises.
    assign vx_launch = scale_speed(Vel, 5'd16 - Ang);
    assign vy_launch = scale_speed(Vel, Ang);

    // Candidate next position in 13-bit signed so ceiling overshoot shows as negative.
    assign nx = $signed({1'b0, x_q}) + $signed({6'b0, vx_q});
    assign ny = $signed({2'b0, y_q}) - 13'(vy_q);

    assign hit_ground = ny > GROUND_Q;
    assign hit_edge   = nx >= X_EDGE_Q;

    assign ball_x = x_q[11:2];
    assign ball_y = y_q[10:2];
    assign busy   = (state_q != IDLE);

    // Next-state and motion datapath; nothing moves except on update ticks.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        armed_d  = armed_q;
        hold_d   = hold_q;
        landed_d = 1'b0;

        if (update) begin
            if (fire) begin
                armed_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (!fire && armed_q) begin
                        vx_d    = vx_launch;
                        vy_d    = $signed({1'b0, vy_launch});
                        x_d     = X_START_Q;
                        y_d     = Y_START_Q;
                        armed_d = 1'b0;
                        state_d = FLIGHT;
                    end
                end

                FLIGHT: begin
                    vy_d = vy_q - 8'(GRAVITY);
                    if (hit_ground) begin
                        x_d      = nx[11:0];
                        y_d      = GROUND_Q[10:0];
                        hold_d   = 5'd0;
                        landed_d = 1'b1;
                        state_d  = LANDED;
                    end else if (hit_edge) begin
                        x_d      = X_MAX_Q;
                        y_d      = (ny < 0) ? 11'd0 : ny[10:0];
                        hold_d   = 5'd0;
                        landed_d = 1'b1;
                        state_d  = LANDED;
                    end else begin
                        x_d = nx[11:0];
                        y_d = (ny < 0) ? 11'd0 : ny[10:0];
                    end
                end

                LANDED: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = 5'd0;
                        x_d     = X_START_Q;
                        y_d     = Y_START_Q;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + 5'd1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and motion registers; reset puts the ball back at the start, disarmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= X_START_Q;
            y_q     <= Y_START_Q;
            vx_q    <= 7'd0;
            vy_q    <= 8'sd0;
            armed_q <= 1'b0;
            hold_q  <= 5'd0;
            landed  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            armed_q <= armed_d;
            hold_q  <= hold_d;
            landed  <= landed_d;
        end
    end

    ball_pixel u_ball (
        .clk   (clk),
        .rst   (rst),
        .px    (xCount),
        .py    (yCount),
        .obj_x (ball_x),
        .obj_y ({1'b0, ball_y}),
        .hit   (ball)
    );

`ifdef BALL_TRAIL_EN
    logic [1:0]           tcnt_q;
    logic [9:0]           tx_q [TRAIL_LEN];
    logic [8:0]           ty_q [TRAIL_LEN];
    logic [TRAIL_LEN-1:0] trail_hit;
    logic                 launch_tick;
    logic                 flight_tick;
    logic                 idle_return;

    assign launch_tick = update && (state_q == IDLE) && (state_d == FLIGHT);
    assign flight_tick = update && (state_q == FLIGHT);
    assign idle_return = update && (state_q == LANDED) && (state_d == IDLE);

    // Trail history: every 4th flight tick the current position is pushed in.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 2'd0;
            for (int i = 0; i < TRAIL_LEN; i++) begin
                tx_q[i] <= 10'(START_X);
                ty_q[i] <= 9'(START_Y);
            end
        end else begin
            if (launch_tick) begin
                tcnt_q <= 2'd0;
            end else if (flight_tick) begin
                tcnt_q <= tcnt_q + 2'd1;
            end

            if (idle_return) begin
                for (int i = 0; i < TRAIL_LEN; i++) begin
                    tx_q[i] <= 10'(START_X);
                    ty_q[i] <= 9'(START_Y);
                end
            end else if (flight_tick && (tcnt_q == 2'd3)) begin
                tx_q[0] <= ball_x;
                ty_q[0] <= ball_y;
                for (int i = 1; i < TRAIL_LEN; i++) begin
                    tx_q[i] <= tx_q[i-1];
                    ty_q[i] <= ty_q[i-1];
                end
            end
        end
    end

    for (genvar g = 0; g < TRAIL_LEN; g++) begin : g_trail
        ball_pixel u_trail (
            .clk   (clk),
            .rst   (rst),
            .px    (xCount),
            .py    (yCount),
            .obj_x (tx_q[g]),
            .obj_y ({1'b0, ty_q[g]}),
            .hit   (trail_hit[g])
        );
    end

    assign trail = |trail_hit;
`else
    assign trail = 1'b0;
`endif

endmodule

// File: tb/tb_ball_launcher.sv
// Self-checking bench for ball_launcher: table-driven flight and pixel
// vectors plus hand-written ceiling, hold/re-arm and mid-flight reset sequences.
module tb_ball_launcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       update;
    logic       fire;
    logic [2:0] Vel;
    logic [4:0] Ang;
    logic [9:0] xCount;
    logic [9:0] yCount;
    logic       ball;
    logic       trail;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       busy;
    logic       landed;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [2:0] vel;
        logic [4:0] ang;
        int         t1x;
        int         t1y;
        int         landTick;
        int         landX;
        int         landY;
    } flightVec_t;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       expHit;
    } pixelVec_t;

    flightVec_t flights [6];
    pixelVec_t  pixels  [7];

    ball_launcher dut (
        .clk    (clk),
        .rst    (rst),
        .update (update),
        .fire   (fire),
        .Vel    (Vel),
        .Ang    (Ang),
        .xCount (xCount),
        .yCount (yCount),
        .ball   (ball),
        .trail  (trail),
        .ball_x (ball_x),
        .ball_y (ball_y),
        .busy   (busy),
        .landed (landed)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequencing.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One frame tick: update high for exactly one clock, outputs sampled 1ns after the edge.
    task automatic applyStimulus(input logic fireVal);
        @(negedge clk);
        update = 1'b1;
        fire   = fireVal;
        @(posedge clk);
        #1;
        update = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b1;
        update = 1'b0;
        fire   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Arm with fire high, then press fire on the next tick.
    task automatic launchBall(input logic [2:0] v, input logic [4:0] a);
        Vel = v;
        Ang = a;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
    endtask

    initial begin
        int landedAt;

        rst    = 1'b1;
        update = 1'b0;
        fire   = 1'b1;
        Vel    = 3'd0;
        Ang    = 5'd0;
        xCount = 10'd0;
        yCount = 10'd0;

        flights[0] = '{3'd0, 5'd8,  44, 423, 18,  78, 425};
        flights[1] = '{3'd0, 5'd0,  46, 425,  2,  50, 425};
        flights[2] = '{3'd5, 5'd4,  60, 419, 34, 639, 361};
        flights[3] = '{3'd2, 5'd12, 45, 416, 74, 264, 425};
        flights[4] = '{3'd3, 5'd2,  56, 423, 18, 294, 425};
        flights[5] = '{3'd1, 5'd16, 42, 417, 66,  42, 425};

        pixels[0] = '{10'd42, 10'd425, 1'b1};
        pixels[1] = '{10'd45, 10'd428, 1'b1};
        pixels[2] = '{10'd46, 10'd425, 1'b0};
        pixels[3] = '{10'd41, 10'd426, 1'b0};
        pixels[4] = '{10'd43, 10'd424, 1'b0};
        pixels[5] = '{10'd44, 10'd429, 1'b0};
        pixels[6] = '{10'd45, 10'd425, 1'b1};

        // Reset state.
        doReset();
        checkOutput("reset busy",   32'(busy),   32'd0);
        checkOutput("reset landed", 32'(landed), 32'd0);
        checkOutput("reset ball",   32'(ball),   32'd0);
        checkOutput("reset trail",  32'(trail),  32'd0);
        checkOutput("reset ball_x", 32'(ball_x), 32'd42);
        checkOutput("reset ball_y", 32'(ball_y), 32'd425);

        // Pixel hit test against the idle ball at (42,425).
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            xCount = pixels[i].px;
            yCount = pixels[i].py;
            @(posedge clk);
            #1;
            checkOutput($sformatf("pixel%0d ball", i), 32'(ball), 32'(pixels[i].expHit));
            checkOutput($sformatf("pixel%0d trail", i), 32'(trail), 32'd0);
        end
        @(negedge clk);
        xCount = 10'd0;
        yCount = 10'd0;

        // Table-driven flights.
        for (int i = 0; i < 6; i++) begin
            doReset();
            launchBall(flights[i].vel, flights[i].ang);
            checkOutput($sformatf("flight%0d launch busy", i), 32'(busy), 32'd1);
            checkOutput($sformatf("flight%0d launch x", i), 32'(ball_x), 32'd42);
            checkOutput($sformatf("flight%0d launch y", i), 32'(ball_y), 32'd425);
            landedAt = 0;
            for (int t = 1; t <= 200 && landedAt == 0; t++) begin
                applyStimulus(1'b0);
                if (t == 1) begin
                    checkOutput($sformatf("flight%0d tick1 x", i), 32'(ball_x), 32'(flights[i].t1x));
                    checkOutput($sformatf("flight%0d tick1 y", i), 32'(ball_y), 32'(flights[i].t1y));
                end
                if (landed === 1'b1) begin
                    landedAt = t;
                    checkOutput($sformatf("flight%0d land x", i), 32'(ball_x), 32'(flights[i].landX));
                    checkOutput($sformatf("flight%0d land y", i), 32'(ball_y), 32'(flights[i].landY));
                end
            end
            checkOutput($sformatf("flight%0d land tick", i), 32'(landedAt), 32'(flights[i].landTick));
            @(posedge clk);
            #1;
            checkOutput($sformatf("flight%0d landed width", i), 32'(landed), 32'd0);
            checkOutput($sformatf("flight%0d landed busy", i), 32'(busy), 32'd1);
        end

        // Ceiling clamp: straight up at full power.
        doReset();
        launchBall(3'd5, 5'd16);
        for (int t = 1; t <= 21; t++) begin
            applyStimulus(1'b0);
            if (t == 19) begin
                checkOutput("ceiling tick19 y", 32'(ball_y), 32'd11);
            end
            if (t == 20) begin
                checkOutput("ceiling tick20 y", 32'(ball_y), 32'd0);
                checkOutput("ceiling tick20 x", 32'(ball_x), 32'd42);
                checkOutput("ceiling tick20 busy", 32'(busy), 32'd1);
            end
            if (t == 21) begin
                checkOutput("ceiling tick21 y", 32'(ball_y), 32'd0);
                checkOutput("ceiling tick21 busy", 32'(busy), 32'd1);
                checkOutput("ceiling tick21 landed", 32'(landed), 32'd0);
            end
        end

        // Hold for 32 ticks with fire held low, then require a re-arm.
        doReset();
        launchBall(3'd0, 5'd0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("hold landed pulse", 32'(landed), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b0);
            if (k == 31) begin
                checkOutput("hold tick31 busy", 32'(busy), 32'd1);
                checkOutput("hold tick31 x", 32'(ball_x), 32'd50);
                checkOutput("hold tick31 landed", 32'(landed), 32'd0);
            end
            if (k == 32) begin
                checkOutput("hold tick32 busy", 32'(busy), 32'd0);
                checkOutput("hold tick32 x", 32'(ball_x), 32'd42);
                checkOutput("hold tick32 y", 32'(ball_y), 32'd425);
            end
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("no relaunch %0d busy", k), 32'(busy), 32'd0);
        end
        applyStimulus(1'b1);
        checkOutput("rearm busy", 32'(busy), 32'd0);
        applyStimulus(1'b0);
        checkOutput("relaunch busy", 32'(busy), 32'd1);

        // Reset mid-flight, with Vel/Ang changes during flight that must be ignored.
        doReset();
        launchBall(3'd0, 5'd8);
        Vel = 3'd5;
        Ang = 5'd0;
        for (int t = 1; t <= 10; t++) begin
            applyStimulus(1'b0);
        end
        checkOutput("midflight tick10 x", 32'(ball_x), 32'd62);
        checkOutput("midflight tick10 y", 32'(ball_y), 32'd416);
        @(negedge clk);
        rst    = 1'b1;
        update = 1'b1;
        fire   = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort busy",   32'(busy),   32'd0);
        checkOutput("abort x",      32'(ball_x), 32'd42);
        checkOutput("abort y",      32'(ball_y), 32'd425);
        checkOutput("abort landed", 32'(landed), 32'd0);
        rst    = 1'b0;
        update = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("post abort %0d busy", k), 32'(busy), 32'd0);
            checkOutput($sformatf("post abort %0d landed", k), 32'(landed), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ball_launcher.md
BALL_LAUNCHER -- requirements
Module: ball_launcher

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: update  in  1  frame-tick enable, one clk wide; all motion/FSM steps occur only on clk edges with update=1.
REQ-004 SHALL have port: fire  in  1  launch button, active-low, sampled only on update ticks.
REQ-005 SHALL have ports: Vel  in  3  power 0..5; Ang  in  5  angle step 0..16.
REQ-006 SHALL have ports: xCount  in  10, yCount  in  10  current VGA pixel coordinate.
REQ-007 SHALL have ports: ball  out  1  ball pixel; trail  out  1  trail pixel.
REQ-008 SHALL have ports: ball_x  out  10, ball_y  out  9  integer ball position; busy  out  1  state != IDLE; landed  out  1  one-clk landing pulse.

Function
REQ-009 SHALL implement FSM IDLE, FLIGHT, LANDED.
REQ-010 SHALL hold position fixed-point in quarter-pixels: x 12-bit unsigned, y 11-bit unsigned, vx 7-bit unsigned, vy 8-bit signed; ball_x = x>>2, ball_y = y>>2.
REQ-011 SHALL, on an update tick in IDLE with fire=0 and armed=1, latch vx=(Vel+1)*(16-Ang) and vy=(Vel+1)*Ang, set x=4*START_X, y=4*START_Y, clear armed, and enter FLIGHT without moving.
REQ-012 SHALL set armed on any update tick with fire=1; armed gates every launch.
REQ-013 SHALL, on each FLIGHT tick, compute x'=x+vx and y'=y-vy in 13-bit signed, then set vy<=vy-GRAVITY.
REQ-014 SHALL clamp y'<0 to y=0 and continue FLIGHT.
REQ-015 SHALL, if y'>4*GROUND_Y, set y=4*GROUND_Y, enter LANDED, and pulse landed.
REQ-016 SHALL, if x'>=4*640 and REQ-015 does not apply, set x=4*X_MAX, enter LANDED, and pulse landed; REQ-015 has priority.
REQ-017 SHALL stay in LANDED for HOLD ticks, counted by a 5-bit counter, then enter IDLE with x and y reset to start.
REQ-018 SHALL ignore Vel/Ang changes outside the launch tick and ignore fire outside IDLE (armed still tracks).
REQ-019 SHALL register ball one clk after xCount/yCount: 1 when ball_x<=xCount<ball_x+4 and ball_y<=yCount<ball_y+4.

Reset
REQ-020 SHALL, on rst=1, set state IDLE, x=168, y=1700, vx=0, vy=0, armed=0, hold counter=0, trail entries=start, ball=0, trail=0, landed=0, busy=0; rst overrides update.
REQ-021 SHALL, on rst mid-FLIGHT or mid-LANDED, abort without a landed pulse.

Configuration
REQ-022 SHALL, with BALL_TRAIL_EN defined, keep 4 past positions shifted in every 4th FLIGHT tick (2-bit tick counter, cleared on launch), drive trail for the same 4x4 test on any entry (registered), and reset entries to start on landing-to-IDLE.
REQ-023 SHALL, without BALL_TRAIL_EN, tie trail to 0 and omit the storage.

Structure
REQ-024 SHALL put in package ball_pkg: START_X=42, START_Y=425, GROUND_Y=425, X_MAX=639, GRAVITY=1, HOLD=32, and the FSM state type.
REQ-025 SHALL instantiate sub-module ball_pixel (10-bit x/y compare, registered hit) once for ball and once per trail entry.

Verification
REQ-026 SHALL cover: Vel=0, Ang=8, fire low on a tick -> FLIGHT; tick 1 ball_x=44, ball_y=423; landed pulses at tick 18 with ball_x=78, ball_y=425.
REQ-027 SHALL cover: Vel=0, Ang=0 -> tick 1 y=1700 (no land); tick 2 landed, ball_x=50, ball_y=425.
REQ-028 SHALL cover: Vel=5, Ang=4 -> right-edge landing at tick 34, ball_x=639, ball_y<425.
REQ-029 SHALL cover: Vel=5, Ang=16 -> tick 20 ball_y=0 (ceiling clamp), busy stays 1.
REQ-030 SHALL cover: fire held low through LANDED -> after 32 ticks IDLE at (42,425), no relaunch until fire seen high then low.
REQ-031 SHALL cover: rst asserted at tick 10 of flight -> next clk busy=0, ball_x=42, ball_y=425, no landed pulse.
